// File: rtl/fs_clkgen_pkg.sv
// Shared types and defaults for the fs clock generator and reset sequencer.
package fs_clkgen_pkg;

  localparam int unsigned DIV_W_DEF       = 8;
  localparam int unsigned SEL_W_DEF       = 2;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned LOCK_FILT_DEF   = 16;
  localparam int unsigned HOLD_CYCLES_DEF = 128;
  localparam int unsigned SCNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } fs_state_e;

  // Master clocks per sample for a given ratio shift.
  function automatic int unsigned period(input int unsigned div_w, input int unsigned div_sel);
    return 32'd1 << (div_w - div_sel);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for a single asynchronous input.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fs_clkgen_seq.sv
// PLL-lock reset sequencer plus runtime-selectable power-of-two fs divider.
module fs_clkgen_seq
  import fs_clkgen_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned LOCK_FILT   = LOCK_FILT_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned SCNT_W      = SCNT_W_DEF
) (
  input  logic              clk_256fs,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic [SEL_W-1:0]  div_sel,
  output logic              rst_out,
  output logic              clk_fs,
  output logic              fs_strobe,
  output logic [SCNT_W-1:0] sample_cnt,
  output logic              lock_lost,
  output logic [1:0]        state
);

  localparam int unsigned FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned IDX_W  = (DIV_W > 1) ? $clog2(DIV_W) : 1;

  logic              lock_s;
  fs_state_e         state_q, state_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [SEL_W-1:0]  div_sel_q, div_sel_d;
  logic              rst_out_q, rst_out_d;
  logic              clk_fs_q, clk_fs_d;
  logic              fs_strobe_q, fs_strobe_d;
  logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic              lock_lost_q, lock_lost_d;
  logic              run_q, run_d;
  logic [DIV_W-1:0]  div_last;
  logic [IDX_W-1:0]  tap;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_256fs),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Lock filter, hold-off and loss detection.
  always_comb begin
    state_d     = state_q;
    filt_cnt_d  = filt_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_W'(LOCK_FILT - 1)) begin
          state_d    = HOLD;
          filt_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          filt_cnt_d = '0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d     = LOST;
          lock_lost_d = 1'b1;
        end
      end
      LOST:    state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Divider; outputs are gated on staying in RUN so lock loss suppresses a coincident strobe.
  always_comb begin
    run_q        = (state_q == RUN);
    run_d        = (state_d == RUN);
    div_last     = DIV_W'(period(DIV_W, 32'(div_sel_q)) - 32'd1);
    tap          = IDX_W'(DIV_W - 1 - 32'(div_sel_q));
    div_cnt_d    = '0;
    div_sel_d    = div_sel_q;
    if (run_q && run_d) begin
      if (div_cnt_q == div_last) begin
        div_sel_d = div_sel;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else if (!run_q && run_d) begin
      div_sel_d = div_sel;
    end
    clk_fs_d     = run_q && run_d && div_cnt_q[tap];
    fs_strobe_d  = run_q && run_d && (div_cnt_q == '0);
    sample_cnt_d = run_d ? sample_cnt_q + SCNT_W'(fs_strobe_d) : '0;
    rst_out_d    = !run_d;
  end

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      filt_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      div_cnt_q    <= '0;
      div_sel_q    <= '0;
      rst_out_q    <= 1'b1;
      clk_fs_q     <= 1'b0;
      fs_strobe_q  <= 1'b0;
      sample_cnt_q <= '0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_cnt_q   <= filt_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      div_cnt_q    <= div_cnt_d;
      div_sel_q    <= div_sel_d;
      rst_out_q    <= rst_out_d;
      clk_fs_q     <= clk_fs_d;
      fs_strobe_q  <= fs_strobe_d;
      sample_cnt_q <= sample_cnt_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign rst_out    = rst_out_q;
  assign clk_fs     = clk_fs_q;
  assign fs_strobe  = fs_strobe_q;
  assign sample_cnt = sample_cnt_q;
  assign lock_lost  = lock_lost_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fs_clkgen_seq.sv
// Scoreboard bench for fs_clkgen_seq: lock sequencing, divider ratios, loss and reset.
module tb_fs_clkgen_seq;
  import fs_clkgen_pkg::*;

  localparam int unsigned SCNT_W = 4;

  logic              clk_256fs = 1'b0;
  logic              rst_n     = 1'b0;
  logic              pll_lock  = 1'b0;
  logic [1:0]        div_sel   = 2'd0;
  logic              rst_out, clk_fs, fs_strobe, lock_lost;
  logic [SCNT_W-1:0] sample_cnt;
  logic [1:0]        state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned cnt;
    int unsigned period;
    int unsigned high;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned since = 0;
  int unsigned high  = 0;

  fs_clkgen_seq #(.SCNT_W(SCNT_W)) dut (
    .clk_256fs  (clk_256fs),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .div_sel    (div_sel),
    .rst_out    (rst_out),
    .clk_fs     (clk_fs),
    .fs_strobe  (fs_strobe),
    .sample_cnt (sample_cnt),
    .lock_lost  (lock_lost),
    .state      (state)
  );

  always #5 clk_256fs = ~clk_256fs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input int unsigned c, input int unsigned p, input int unsigned h);
    exp_t e;
    e.cnt = c; e.period = p; e.high = h;
    sb_q.push_back(e);
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_256fs);
      n++;
    end while (fs_strobe !== 1'b1 && n < 2000);
    if (fs_strobe !== 1'b1) check(name, 32'(fs_strobe), 32'd1);
  endtask

  task automatic measure_lock(output int hold_at, output int fall_at);
    hold_at = -1;
    fall_at = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk_256fs);
      if (hold_at < 0 && state == HOLD) hold_at = n;
      if (rst_out === 1'b0) begin
        fall_at = n;
        break;
      end
    end
  endtask

  // Monitor: every strobe pops one expectation; period/high count cover the preceding sample.
  always @(negedge clk_256fs) begin
    if (fs_strobe === 1'b1) begin
      check("strobe_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("sample_cnt", 32'(sample_cnt), mon_e.cnt);
        if (mon_e.period != 0) begin
          check("period", since, mon_e.period);
          check("clk_fs_high", high, mon_e.high);
        end
      end
      since = 1;
      high  = (clk_fs === 1'b1) ? 1 : 0;
    end else begin
      since++;
      high += (clk_fs === 1'b1) ? 1 : 0;
    end
  end

  initial begin
    int   hold_at, fall_at, n;
    logic saw_low, early;

    repeat (3) @(negedge clk_256fs);
    check("rst_rst_out", 32'(rst_out), 32'd1);
    check("rst_clk_fs", 32'(clk_fs), 32'd0);
    check("rst_fs_strobe", 32'(fs_strobe), 32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_state", 32'(state), 32'(WAIT_LOCK));

    rst_n = 1'b1;
    repeat (5) @(negedge clk_256fs);
    check("idle_state", 32'(state), 32'(WAIT_LOCK));

    // Clean lock with the base ratio.
    pll_lock = 1'b1;
    push(1, 0, 0); push(2, 256, 128); push(3, 256, 128);
    measure_lock(hold_at, fall_at);
    check_range("lock_latency", fall_at, 146, 148);
    check_range("hold_entry", hold_at, 17, 19);
    check("run_state", 32'(state), 32'(RUN));
    @(negedge clk_256fs);
    check("first_strobe", 32'(fs_strobe), 32'd1);
    wait_strobe("strobe2_timeout");
    wait_strobe("strobe3_timeout");

    // Mid-period ratio change: current period finishes at 256, then 64.
    push(4, 256, 128);
    for (int k = 5; k <= 7; k++) push(k, 64, 32);
    repeat (37) @(negedge clk_256fs);
    div_sel = 2'd2;
    repeat (4) wait_strobe("div_change_timeout");

    // Sample counter wrap on a 4-bit counter.
    for (int k = 8; k <= 17; k++) push(k & 15, 64, 32);
    repeat (10) wait_strobe("wrap_timeout");

    // Lock loss in RUN while clk_fs is high.
    repeat (40) @(negedge clk_256fs);
    pll_lock = 1'b0;
    n = 0;
    do begin
      @(negedge clk_256fs);
      n++;
    end while (state != LOST && n < 10);
    check_range("loss_latency", n, 1, 3);
    check("lost_state", 32'(state), 32'(LOST));
    check("lost_rst_out", 32'(rst_out), 32'd1);
    check("lost_lock_lost", 32'(lock_lost), 32'd1);
    check("lost_clk_fs", 32'(clk_fs), 32'd0);
    check("lost_sample_cnt", 32'(sample_cnt), 32'd0);
    check("lost_fs_strobe", 32'(fs_strobe), 32'd0);
    @(negedge clk_256fs);
    check("after_lost_state", 32'(state), 32'(WAIT_LOCK));
    check("after_lost_rst_out", 32'(rst_out), 32'd1);

    // Relock keeps the sticky flag and uses div_sel=2 from entry.
    repeat (3) @(negedge clk_256fs);
    pll_lock = 1'b1;
    push(1, 0, 0); push(2, 64, 32);
    measure_lock(hold_at, fall_at);
    check_range("relock_latency", fall_at, 146, 148);
    check("lock_lost_sticky", 32'(lock_lost), 32'd1);
    wait_strobe("relock_strobe1_timeout");
    wait_strobe("relock_strobe2_timeout");

    // Asynchronous reset mid-period.
    repeat (40) @(negedge clk_256fs);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rst_out", 32'(rst_out), 32'd1);
    check("arst_clk_fs", 32'(clk_fs), 32'd0);
    check("arst_fs_strobe", 32'(fs_strobe), 32'd0);
    check("arst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("arst_lock_lost", 32'(lock_lost), 32'd0);
    check("arst_state", 32'(state), 32'(WAIT_LOCK));

    // Lock drop during HOLD.
    @(negedge clk_256fs);
    rst_n   = 1'b1;
    saw_low = 1'b0;
    n = 0;
    do begin
      @(negedge clk_256fs);
      n++;
      if (rst_out !== 1'b1) saw_low = 1'b1;
    end while (state != HOLD && n < 100);
    check("hold_reached", 32'(state), 32'(HOLD));
    repeat (50) begin
      @(negedge clk_256fs);
      if (rst_out !== 1'b1) saw_low = 1'b1;
    end
    pll_lock = 1'b0;
    n = 0;
    do begin
      @(negedge clk_256fs);
      n++;
      if (rst_out !== 1'b1) saw_low = 1'b1;
    end while (state != WAIT_LOCK && n < 10);
    check_range("hold_abort_latency", n, 1, 3);
    check("hold_abort_state", 32'(state), 32'(WAIT_LOCK));
    check("hold_abort_lock_lost", 32'(lock_lost), 32'd0);
    check("hold_rst_out_held", 32'(saw_low), 32'd0);

    // One-cycle lock glitch restarts the filter.
    repeat (5) @(negedge clk_256fs);
    pll_lock = 1'b1;
    early    = 1'b0;
    repeat (10) begin
      @(negedge clk_256fs);
      if (state != WAIT_LOCK) early = 1'b1;
    end
    pll_lock = 1'b0;
    @(negedge clk_256fs);
    if (state != WAIT_LOCK) early = 1'b1;
    pll_lock = 1'b1;
    push(1, 0, 0);
    measure_lock(hold_at, fall_at);
    check("glitch_no_early_hold", 32'(early), 32'd0);
    check_range("glitch_hold_entry", hold_at, 17, 19);
    check_range("glitch_latency", fall_at, 146, 148);
    wait_strobe("glitch_strobe_timeout");
    repeat (3) @(negedge clk_256fs);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
